memory_io_mux_latched: RTL and testbench
========================================

Name: memory_io_mux_latched

Overview:
Parametrised successor of the CPU-side memory/IO address decoder. It splits the single data-memory read/write interface between RAM and a configurable window of memory-mapped IO:
- N registered output ports with write strobes.
- M captured input ports, each with a pending flag.
- One status register.

IO reads are aligned to the 1-cycle RAM read latency, so the core sees uniform read timing regardless of the target.

Parameters:
ADDR_BITS, 8, memory address width
DATA_BITS, 8, data width
NUM_OUT_PORTS, 4, output port count (1..8)
NUM_IN_PORTS, 4, input port count (1..DATA_BITS)
OUT_BASE, 'hf0, address of out port 0; port i at OUT_BASE+i
IN_BASE, 'hf8, address of in port 0; port j at IN_BASE+j
STATUS_ADDR, 'hff, status register address; windows must not overlap

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
rd_mem_en  in  1  core read request
rd_mem_addr  in  ADDR_BITS  core read address
rd_mem_data  out  DATA_BITS  read data, valid the cycle after the request
wr_mem_en  in  1  core write request
wr_mem_addr  in  ADDR_BITS  core write address
wr_mem_data  in  DATA_BITS  core write data
rd_ram_en  out  1  RAM read enable
rd_ram_addr  out  ADDR_BITS  RAM read address (passthrough)
rd_ram_data  in  DATA_BITS  RAM read data (1-cycle latency)
wr_ram_en  out  1  RAM write enable
wr_ram_addr  out  ADDR_BITS  RAM write address (passthrough)
wr_ram_data  out  DATA_BITS  RAM write data (passthrough)
out_ports  out  NUM_OUT_PORTS*DATA_BITS  latched output values; port i at bits [i*DATA_BITS +: DATA_BITS]
out_port_write_en  out  NUM_OUT_PORTS  per-port one-cycle update strobe
in_ports  in  NUM_IN_PORTS*DATA_BITS  external input data, same packing as out_ports
in_port_strobe  in  NUM_IN_PORTS  per-port capture pulse, synchronous to clk

Behaviour:
- Decode:
  - IO hit = address in the out window, the in window, or equal to STATUS_ADDR.
  - rd_ram_en = rd_mem_en & ~rd IO hit.
  - wr_ram_en = wr_mem_en & ~wr IO hit.
  - Address/data to RAM are combinational passthrough.
- Out ports:
  - wr_mem_en to OUT_BASE+i: out latch i <= wr_mem_data at the edge; out_port_write_en[i] = 1 for exactly the following cycle.
  - Latch holds its value until the next write to it.
  - Back-to-back writes to the same port give a strobe on consecutive cycles, with the latch carrying the latest data.
- In ports:
  - in_port_strobe[j] = 1: hold reg j <= in_ports slice j; pending[j] <= 1.
  - A read of IN_BASE+j returns hold reg j and clears pending[j] at the same edge.
  - Strobe and read of the same port in the same cycle: the read returns the old hold value; the hold reg takes the new data; pending stays 1 (set wins).
- Status: reads return pending bits in [NUM_IN_PORTS-1:0]; upper bits read 0. Reading status does not clear anything.
- Writes to the in window or STATUS_ADDR are dropped: no RAM write, no state change.
- Reads of out port i return latch i; this does not affect the strobe.
- Read path, 1-cycle latency:
  - At the edge, sel_q <= {NONE, RAM, IO}; for an IO read, io_rd_q <= the selected IO value (pre-edge state).
  - Cycle N+1: rd_mem_data = rd_ram_data if sel_q==RAM, io_rd_q if IO, 0 if NONE.
- Simultaneous write and read of the same out port: the read returns the old latch value.
- Simultaneous read and write to different targets (RAM/IO) are fully independent.
- Reset (synchronous, wins over everything):
  - out latches, hold regs and pending all cleared to 0.
  - out_port_write_en = 0; sel_q = NONE, so rd_mem_data = 0 the cycle after reset; io_rd_q = 0.
  - A read or write issued in the reset cycle is discarded. RAM enables are combinational and may still pulse; this is acceptable.
- Addresses outside all windows, including gaps in partially populated windows, with port index ≥ count:
  - Inside OUT_BASE..OUT_BASE+7 or IN_BASE..IN_BASE+7 but index ≥ count: treated as IO, reads return 0, writes are dropped.

Test Plan:
1. Write 'h5a to 'hf2 → the next cycle shows out_port_write_en=4'b0100 for one cycle and out_ports[23:16]='h5a; wr_ram_en=0 during the write; the port holds 'h5a for 10 idle cycles.
2. Write 'h33 to 'h10, then read 'h10 → wr_ram_en=1, and rd_ram_en=1 with the read. rd_mem_data = rd_ram_data ('h33 from the RAM model) one cycle after the read; 0 on idle cycles.
3. Pulse in_port_strobe[1] with slice 1='hc4 → a status read returns 'h02. A read of 'hf9 returns 'hc4 and the next status read returns 'h00.
4. Strobe port 0 with 'h11, then in one cycle strobe 'h22 and read 'hf8 → the read returns 'h11, pending[0] stays 1, and a second read returns 'h22.
5. Write 'h77 to 'hf0 and read 'hf0 in the same cycle → the read returns the old value 0, and a subsequent read returns 'h77. Writes to 'hf8 and 'hff change nothing and leave wr_ram_en=0.
6. Assert reset with out ports and pending set, and a read to 'hf8 in flight → all outputs are 0 the cycle after reset, including rd_mem_data and strobes, and status reads 0.

Source files
------------

// File: rtl/memory_io_mux_latched.sv
// Splits the core's data-memory port between RAM and a window of memory-mapped IO
// (latched output ports, captured input ports with pending flags, one status register).
// Reads return one cycle after the request for every target; there is no backpressure.
module memory_io_mux_latched #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_OUT_PORTS = 4,
  parameter int NUM_IN_PORTS  = 4,
  parameter int OUT_BASE      = 'hf0,
  parameter int IN_BASE       = 'hf8,
  parameter int STATUS_ADDR   = 'hff
) (
  input  logic                                 clk,
  input  logic                                 reset,
  // core side
  input  logic                                 rd_mem_en,
  input  logic [ADDR_BITS-1:0]                 rd_mem_addr,
  output logic [DATA_BITS-1:0]                 rd_mem_data,
  input  logic                                 wr_mem_en,
  input  logic [ADDR_BITS-1:0]                 wr_mem_addr,
  input  logic [DATA_BITS-1:0]                 wr_mem_data,
  // RAM side
  output logic                                 rd_ram_en,
  output logic [ADDR_BITS-1:0]                 rd_ram_addr,
  input  logic [DATA_BITS-1:0]                 rd_ram_data,
  output logic                                 wr_ram_en,
  output logic [ADDR_BITS-1:0]                 wr_ram_addr,
  output logic [DATA_BITS-1:0]                 wr_ram_data,
  // IO side
  output logic [NUM_OUT_PORTS*DATA_BITS-1:0]   out_ports,
  output logic [NUM_OUT_PORTS-1:0]             out_port_write_en,
  input  logic [NUM_IN_PORTS*DATA_BITS-1:0]    in_ports,
  input  logic [NUM_IN_PORTS-1:0]              in_port_strobe
);

  // Read-path source selected at the request edge, consumed the following cycle.
  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_RAM  = 2'd1;
  localparam logic [1:0] SEL_IO   = 2'd2;

  // Each port window spans eight addresses regardless of how many ports are populated.
  localparam logic [ADDR_BITS-1:0] L_OUT_BASE = ADDR_BITS'(OUT_BASE);
  localparam logic [ADDR_BITS-1:0] L_IN_BASE  = ADDR_BITS'(IN_BASE);
  localparam logic [ADDR_BITS-1:0] L_STATUS   = ADDR_BITS'(STATUS_ADDR);
  localparam logic [ADDR_BITS-1:0] L_WIN      = ADDR_BITS'(8);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0]     r_out  [NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0] r_out_we;
  logic [DATA_BITS-1:0]     r_hold [NUM_IN_PORTS];
  logic [NUM_IN_PORTS-1:0]  r_pend;
  logic [1:0]               r_sel;
  logic [DATA_BITS-1:0]     r_io_rd;

  // ---------------------------------------------------------------------------
  // Address decode (read and write sides decoded independently)
  // ---------------------------------------------------------------------------
  logic [ADDR_BITS-1:0]     w_rd_out_off;
  logic [ADDR_BITS-1:0]     w_rd_in_off;
  logic [ADDR_BITS-1:0]     w_wr_out_off;
  logic [ADDR_BITS-1:0]     w_wr_in_off;
  logic                     w_rd_is_status;
  logic                     w_rd_out_hit;
  logic                     w_rd_in_hit;
  logic                     w_rd_io_hit;
  logic                     w_wr_is_status;
  logic                     w_wr_out_hit;
  logic                     w_wr_in_hit;
  logic                     w_wr_io_hit;
  logic [2:0]               w_rd_out_idx;
  logic [2:0]               w_rd_in_idx;
  logic [2:0]               w_wr_out_idx;
  logic [NUM_OUT_PORTS-1:0] w_rd_out_sel;
  logic [NUM_OUT_PORTS-1:0] w_wr_out_sel;
  logic [NUM_IN_PORTS-1:0]  w_rd_in_sel;
  logic [DATA_BITS-1:0]     w_io_rd_val;

  // Offsets into each window; an unsigned offset below 8 means the address is inside.
  assign w_rd_out_off = rd_mem_addr - L_OUT_BASE;
  assign w_rd_in_off  = rd_mem_addr - L_IN_BASE;
  assign w_wr_out_off = wr_mem_addr - L_OUT_BASE;
  assign w_wr_in_off  = wr_mem_addr - L_IN_BASE;

  // Status takes priority so it can sit at the top of a port window.
  assign w_rd_is_status = (rd_mem_addr == L_STATUS);
  assign w_rd_out_hit   = !w_rd_is_status && (w_rd_out_off < L_WIN);
  assign w_rd_in_hit    = !w_rd_is_status && !w_rd_out_hit && (w_rd_in_off < L_WIN);
  assign w_rd_io_hit    = w_rd_is_status || w_rd_out_hit || w_rd_in_hit;

  assign w_wr_is_status = (wr_mem_addr == L_STATUS);
  assign w_wr_out_hit   = !w_wr_is_status && (w_wr_out_off < L_WIN);
  assign w_wr_in_hit    = !w_wr_is_status && !w_wr_out_hit && (w_wr_in_off < L_WIN);
  assign w_wr_io_hit    = w_wr_is_status || w_wr_out_hit || w_wr_in_hit;

  assign w_rd_out_idx = w_rd_out_off[2:0];
  assign w_rd_in_idx  = w_rd_in_off[2:0];
  assign w_wr_out_idx = w_wr_out_off[2:0];

  // One-hot port selects; unpopulated indices inside a window match nothing,
  // so reads of them return 0 and writes to them are dropped.
  always_comb begin
    w_rd_out_sel = '0;
    w_wr_out_sel = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      w_rd_out_sel[i] = rd_mem_en && w_rd_out_hit && (w_rd_out_idx == 3'(i));
      w_wr_out_sel[i] = wr_mem_en && w_wr_out_hit && (w_wr_out_idx == 3'(i));
    end
  end

  // One-hot input-port read select, also used to clear the pending flag.
  always_comb begin
    w_rd_in_sel = '0;
    for (int j = 0; j < NUM_IN_PORTS; j++) begin
      w_rd_in_sel[j] = rd_mem_en && w_rd_in_hit && (w_rd_in_idx == 3'(j));
    end
  end

  // ---------------------------------------------------------------------------
  // RAM passthrough: enables are masked by IO hits, address/data pass straight through
  // ---------------------------------------------------------------------------
  assign rd_ram_en   = rd_mem_en && !w_rd_io_hit;
  assign rd_ram_addr = rd_mem_addr;
  assign wr_ram_en   = wr_mem_en && !w_wr_io_hit;
  assign wr_ram_addr = wr_mem_addr;
  assign wr_ram_data = wr_mem_data;

  // ---------------------------------------------------------------------------
  // Output ports
  // ---------------------------------------------------------------------------

  // Latch written data and raise that port's strobe for exactly the next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        r_out[i] <= '0;
      end
      r_out_we <= '0;
    end else begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        if (w_wr_out_sel[i]) begin
          r_out[i] <= wr_mem_data;
        end
      end
      r_out_we <= w_wr_out_sel;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUT_PORTS; gi++) begin : g_out_pack
      assign out_ports[gi*DATA_BITS +: DATA_BITS] = r_out[gi];
    end
  endgenerate

  assign out_port_write_en = r_out_we;

  // ---------------------------------------------------------------------------
  // Input ports
  // ---------------------------------------------------------------------------

  // Capture on strobe and set pending; a read clears pending unless a new strobe lands
  // in the same cycle, in which case the set wins and the read sees the old hold value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < NUM_IN_PORTS; j++) begin
        r_hold[j] <= '0;
      end
      r_pend <= '0;
    end else begin
      for (int j = 0; j < NUM_IN_PORTS; j++) begin
        if (in_port_strobe[j]) begin
          r_hold[j] <= in_ports[j*DATA_BITS +: DATA_BITS];
          r_pend[j] <= 1'b1;
        end else if (w_rd_in_sel[j]) begin
          r_pend[j] <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------

  // Select the IO value from pre-edge state; status exposes pending bits zero-extended.
  always_comb begin
    w_io_rd_val = '0;
    if (w_rd_is_status) begin
      for (int j = 0; j < NUM_IN_PORTS; j++) begin
        w_io_rd_val[j] = r_pend[j];
      end
    end else begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        if (w_rd_out_sel[i]) begin
          w_io_rd_val = r_out[i];
        end
      end
      for (int j = 0; j < NUM_IN_PORTS; j++) begin
        if (w_rd_in_sel[j]) begin
          w_io_rd_val = r_hold[j];
        end
      end
    end
  end

  // Register the read source (and the IO value) so IO reads line up with RAM latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel   <= SEL_NONE;
      r_io_rd <= '0;
    end else if (!rd_mem_en) begin
      r_sel   <= SEL_NONE;
    end else if (w_rd_io_hit) begin
      r_sel   <= SEL_IO;
      r_io_rd <= w_io_rd_val;
    end else begin
      r_sel   <= SEL_RAM;
    end
  end

  // Return data for the request issued last cycle; idle cycles read as 0.
  always_comb begin
    case (r_sel)
      SEL_RAM: rd_mem_data = rd_ram_data;
      SEL_IO:  rd_mem_data = r_io_rd;
      default: rd_mem_data = '0;
    endcase
  end

endmodule

// File: tb/tb_memory_io_mux_latched.sv
// Bench for memory_io_mux_latched: directed scenarios followed by randomized traffic,
// every cycle compared against a transaction-level model of the address map.
// The RAM is a simple behavioural array with one-cycle read latency.
module tb_memory_io_mux_latched;

  localparam int NO     = 4;
  localparam int NI     = 4;
  localparam int OUT_LO = 'hf0;
  localparam int IN_LO  = 'hf8;
  localparam int ST     = 'hff;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_mem_en;
  logic [7:0]  rd_mem_addr;
  logic [7:0]  rd_mem_data;
  logic        wr_mem_en;
  logic [7:0]  wr_mem_addr;
  logic [7:0]  wr_mem_data;
  logic        rd_ram_en;
  logic [7:0]  rd_ram_addr;
  logic [7:0]  rd_ram_data;
  logic        wr_ram_en;
  logic [7:0]  wr_ram_addr;
  logic [7:0]  wr_ram_data;
  logic [31:0] out_ports;
  logic [3:0]  out_port_write_en;
  logic [31:0] in_ports;
  logic [3:0]  in_port_strobe;

  memory_io_mux_latched dut (
    .clk               (clk),
    .reset             (reset),
    .rd_mem_en         (rd_mem_en),
    .rd_mem_addr       (rd_mem_addr),
    .rd_mem_data       (rd_mem_data),
    .wr_mem_en         (wr_mem_en),
    .wr_mem_addr       (wr_mem_addr),
    .wr_mem_data       (wr_mem_data),
    .rd_ram_en         (rd_ram_en),
    .rd_ram_addr       (rd_ram_addr),
    .rd_ram_data       (rd_ram_data),
    .wr_ram_en         (wr_ram_en),
    .wr_ram_addr       (wr_ram_addr),
    .wr_ram_data       (wr_ram_data),
    .out_ports         (out_ports),
    .out_port_write_en (out_port_write_en),
    .in_ports          (in_ports),
    .in_port_strobe    (in_port_strobe)
  );

  always #5 clk = ~clk;

  // Behavioural RAM, one-cycle read latency, read-before-write on the same edge.
  bit [7:0] ram [256];
  always @(posedge clk) begin
    if (wr_ram_en) ram[wr_ram_addr] <= wr_ram_data;
    if (rd_ram_en) rd_ram_data <= ram[rd_ram_addr];
  end

  // Reference model of the visible address map.
  logic [7:0]    m_out  [NO];
  logic [7:0]    m_hold [NI];
  logic [NI-1:0] m_pend;
  bit   [7:0]    m_mem  [256];

  int   n_checks = 0;
  int   n_fail   = 0;
  logic obs_rd_ram_en;
  logic obs_wr_ram_en;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_out_win(input logic [7:0] a);
    return int'(a) >= OUT_LO && int'(a) <= OUT_LO + 7 && int'(a) != ST;
  endfunction

  function automatic bit in_in_win(input logic [7:0] a);
    return int'(a) >= IN_LO && int'(a) <= IN_LO + 7 && int'(a) != ST;
  endfunction

  function automatic bit is_io(input logic [7:0] a);
    return in_out_win(a) || in_in_win(a) || int'(a) == ST;
  endfunction

  function automatic logic [7:0] model_read(input logic [7:0] a);
    int k;
    if (int'(a) == ST) return {4'b0000, m_pend};
    if (in_out_win(a)) begin
      k = int'(a) - OUT_LO;
      return (k < NO) ? m_out[k] : 8'h00;
    end
    if (in_in_win(a)) begin
      k = int'(a) - IN_LO;
      return (k < NI) ? m_hold[k] : 8'h00;
    end
    return m_mem[a];
  endfunction

  function automatic logic [31:0] model_ports();
    logic [31:0] p;
    for (int i = 0; i < NO; i++) p[i*8 +: 8] = m_out[i];
    return p;
  endfunction

  // One clock cycle: drive, check combinational outputs, advance model, check registered outputs.
  task automatic step(input bit rst, input bit re, input logic [7:0] ra,
                      input bit we, input logic [7:0] wa, input logic [7:0] wd,
                      input logic [3:0] stb, input logic [31:0] ind);
    logic [7:0] exp_rd;
    logic [3:0] exp_we;
    int         k;
    reset          = rst;
    rd_mem_en      = re;
    rd_mem_addr    = ra;
    wr_mem_en      = we;
    wr_mem_addr    = wa;
    wr_mem_data    = wd;
    in_port_strobe = stb;
    in_ports       = ind;
    #1;
    obs_rd_ram_en = rd_ram_en;
    obs_wr_ram_en = wr_ram_en;
    chk("rd_ram_en", rd_ram_en, re && !is_io(ra));
    chk("wr_ram_en", wr_ram_en, we && !is_io(wa));
    chk("rd_ram_addr", rd_ram_addr, ra);
    chk("wr_ram_addr", wr_ram_addr, wa);
    chk("wr_ram_data", wr_ram_data, wd);

    exp_we = 4'b0000;
    if (rst) begin
      exp_rd = 8'h00;
      for (int i = 0; i < NO; i++) m_out[i] = 8'h00;
      for (int j = 0; j < NI; j++) m_hold[j] = 8'h00;
      m_pend = '0;
    end else begin
      exp_rd = re ? model_read(ra) : 8'h00;
      if (we && in_out_win(wa)) begin
        k = int'(wa) - OUT_LO;
        if (k < NO) begin
          m_out[k]  = wd;
          exp_we[k] = 1'b1;
        end
      end
      if (re && in_in_win(ra)) begin
        k = int'(ra) - IN_LO;
        if (k < NI) m_pend[k] = 1'b0;
      end
      for (int j = 0; j < NI; j++) begin
        if (stb[j]) begin
          m_hold[j] = ind[j*8 +: 8];
          m_pend[j] = 1'b1;
        end
      end
    end
    // The RAM write enable is combinational, so a RAM write lands even during reset.
    if (we && !is_io(wa)) m_mem[wa] = wd;

    @(posedge clk);
    #1;
    chk("rd_mem_data", rd_mem_data, exp_rd);
    chk("out_port_write_en", out_port_write_en, exp_we);
    chk("out_ports", out_ports, model_ports());
  endtask

  task automatic idle();
    step(0, 0, 8'h00, 0, 8'h00, 8'h00, 4'h0, 32'h0);
  endtask

  function automatic logic [7:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return 8'(OUT_LO + $urandom_range(0, 15));
      1:       return 8'($urandom_range(0, 15));
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    reset = 1'b1; rd_mem_en = 0; rd_mem_addr = 0; wr_mem_en = 0; wr_mem_addr = 0;
    wr_mem_data = 0; in_ports = 0; in_port_strobe = 0;
    for (int i = 0; i < NO; i++) m_out[i] = 8'h00;
    for (int j = 0; j < NI; j++) m_hold[j] = 8'h00;
    m_pend = '0;

    // Reset state
    step(1, 0, 8'h00, 0, 8'h00, 8'h00, 4'h0, 32'h0);
    chk("reset_rd_mem_data", rd_mem_data, 8'h00);
    chk("reset_out_ports", out_ports, 32'h0);

    // 1: out port write, strobe for one cycle, value holds
    step(0, 0, 8'h00, 1, 8'hf2, 8'h5a, 4'h0, 32'h0);
    chk("t1_wr_ram_en", obs_wr_ram_en, 1'b0);
    chk("t1_strobe", out_port_write_en, 4'b0100);
    chk("t1_port2", out_ports[23:16], 8'h5a);
    for (int n = 0; n < 10; n++) begin
      idle();
      chk("t1_port2_hold", out_ports[23:16], 8'h5a);
    end
    chk("t1_strobe_off", out_port_write_en, 4'b0000);

    // 2: RAM write then read through the passthrough
    step(0, 0, 8'h00, 1, 8'h10, 8'h33, 4'h0, 32'h0);
    chk("t2_wr_ram_en", obs_wr_ram_en, 1'b1);
    step(0, 1, 8'h10, 0, 8'h00, 8'h00, 4'h0, 32'h0);
    chk("t2_rd_ram_en", obs_rd_ram_en, 1'b1);
    chk("t2_rd_data", rd_mem_data, 8'h33);
    idle();
    chk("t2_idle_zero", rd_mem_data, 8'h00);

    // 3: input capture, status, read clears pending
    step(0, 0, 8'h00, 0, 8'h00, 8'h00, 4'b0010, 32'h0000_c400);
    step(0, 1, 8'hff, 0, 8'h00, 8'h00, 4'h0, 32'h0);
    chk("t3_status", rd_mem_data, 8'h02);
    step(0, 1, 8'hf9, 0, 8'h00, 8'h00, 4'h0, 32'h0);
    chk("t3_hold1", rd_mem_data, 8'hc4);
    step(0, 1, 8'hff, 0, 8'h00, 8'h00, 4'h0, 32'h0);
    chk("t3_status_clr", rd_mem_data, 8'h00);

    // 4: strobe and read of the same port in one cycle
    step(0, 0, 8'h00, 0, 8'h00, 8'h00, 4'b0001, 32'h0000_0011);
    step(0, 1, 8'hf8, 0, 8'h00, 8'h00, 4'b0001, 32'h0000_0022);
    chk("t4_old_hold", rd_mem_data, 8'h11);
    step(0, 1, 8'hff, 0, 8'h00, 8'h00, 4'h0, 32'h0);
    chk("t4_pending_kept", rd_mem_data, 8'h01);
    step(0, 1, 8'hf8, 0, 8'h00, 8'h00, 4'h0, 32'h0);
    chk("t4_new_hold", rd_mem_data, 8'h22);

    // 5: simultaneous write/read of an out port; dropped writes
    step(0, 1, 8'hf0, 1, 8'hf0, 8'h77, 4'h0, 32'h0);
    chk("t5_old_latch", rd_mem_data, 8'h00);
    step(0, 1, 8'hf0, 0, 8'h00, 8'h00, 4'h0, 32'h0);
    chk("t5_new_latch", rd_mem_data, 8'h77);
    step(0, 0, 8'h00, 1, 8'hf8, 8'haa, 4'h0, 32'h0);
    chk("t5_in_wr_drop", obs_wr_ram_en, 1'b0);
    step(0, 0, 8'h00, 1, 8'hff, 8'haa, 4'h0, 32'h0);
    chk("t5_st_wr_drop", obs_wr_ram_en, 1'b0);
    step(0, 1, 8'hf8, 0, 8'h00, 8'h00, 4'h0, 32'h0);
    chk("t5_hold_intact", rd_mem_data, 8'h22);
    chk("t5_ports_intact", out_ports, 32'h005a_0077);

    // 6: reset with state set and a read issued in the reset cycle
    step(0, 0, 8'h00, 1, 8'hf1, 8'h99, 4'b1111, 32'hdead_beef);
    step(1, 1, 8'hf8, 0, 8'h00, 8'h00, 4'h0, 32'h0);
    chk("t6_rd_zero", rd_mem_data, 8'h00);
    chk("t6_strobe_zero", out_port_write_en, 4'b0000);
    chk("t6_ports_zero", out_ports, 32'h0);
    step(0, 1, 8'hff, 0, 8'h00, 8'h00, 4'h0, 32'h0);
    chk("t6_status_zero", rd_mem_data, 8'h00);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 2) != 0), rand_addr(),
           ($urandom_range(0, 2) != 0), rand_addr(), 8'($urandom),
           ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0,
           32'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
